binary_map_pingpong_buffer: RTL

Parametrised two-bank (ping-pong) on-chip store for binary feature maps.
- A producer fills one bank while a consumer reads the other.
- Banks swap through a frame-done handshake.
- Adds configurable word width, map dimension, frame-level flow control, an error flag and an optional bit-masked write.
- Sits between the binarisation stage (writer) and the convolution engine (reader).

---
 rtl/binary_map_pingpong_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/binary_map_pingpong_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | binary_map_pingpong_buffer: two-bank ping-pong store for binary maps,    |
// | frame handshake, sticky error. Option macro: BINARY_MAP_BITMASK_EN       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module binary_map_pingpong_buffer #(
  parameter int DIMEN  = 1024,
  parameter int DATA_W = 16,
  parameter int DEPTH  = DIMEN * DIMEN / DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RETN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] D,
  input  logic              WDONE,
  output logic              WRDY,
  input  logic              CEN,
  input  logic [ADDR_W-1:0] RA,
  output logic [DATA_W-1:0] Q,
  output logic              QV,
  input  logic              RDONE,
  output logic              RRDY,
  output logic              WBANK,
  output logic              RBANK,
  output logic [1:0]        FULL_CNT,
`ifdef BINARY_MAP_BITMASK_EN
  input  logic [DATA_W-1:0] M,
`endif
  output logic              ERR
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        full_q, full_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              qv_q, qv_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic              wrdy, rrdy, wa_ok, ra_ok;
  logic              wr_en, rd_en, wdone_acc, rdone_acc, err_set;
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    wrdy      = ~full_q[wr_ptr_q];
    rrdy      = full_q[rd_ptr_q];
    wa_ok     = {1'b0, WA} < DEPTH_L;
    ra_ok     = {1'b0, RA} < DEPTH_L;
    wr_en     = ~WEN & wrdy & RETN & wa_ok;
    wdone_acc = WDONE & wrdy & RETN;
    rd_en     = ~CEN & rrdy & RETN & ra_ok;
    rdone_acc = RDONE & rrdy & RETN;
    // Dropped writes/WDONE and any out-of-range strobe are errors; RDONE on
    // an empty bank is silently ignored.
    err_set   = RETN & ((~WEN & ~(wrdy & wa_ok)) | (WDONE & ~wrdy) | (~CEN & ~ra_ok));
`ifdef BINARY_MAP_BITMASK_EN
    wr_word   = (mem_q[wr_ptr_q][WA] & ~M) | (D & M);
`else
    wr_word   = D;
`endif
  end

  // WDONE needs a non-full bank and RDONE a full one, so both updates never collide.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wdone_acc) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (rdone_acc) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    qv_d  = rd_en;
    err_d = err_q | err_set;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      full_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      qv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      qv_q     <= qv_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; Q is gated by the valid flop instead.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q][WA] <= wr_word;
    if (rd_en) rd_data_q <= mem_q[rd_ptr_q][RA];
  end

  always_comb begin
    WRDY     = wrdy;
    RRDY     = rrdy;
    WBANK    = wr_ptr_q;
    RBANK    = rd_ptr_q;
    FULL_CNT = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    ERR      = err_q;
    QV       = qv_q;
    Q        = qv_q ? rd_data_q : '0;
  end

endmodule
`default_nettype wire
